ecg_peak_detector: RTL and testbench
====================================

Name: ecg_peak_detector

Overview:
- Streaming R-peak detector for float32 (IEEE-754 single) ECG samples; sits directly downstream of the float comparator and instantiates it for every magnitude decision.
- Takes filtered samples on a valid/ready stream and tracks the maximum of each supra-threshold excursion.
- Emits one peak record per excursion: value, sample index and R-R interval. A refractory window suppresses double detections.

Parameters:
- IDX_W, 16, width of the sample index counter and the R-R interval (modulo 2^IDX_W).
- REFRACT, 72, samples ignored after each emitted peak (200 ms at 360 Hz); range 1..2^IDX_W-1.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  detector run; low = idle and clear
- threshold  in  32  float32 detection threshold; read on every accepted sample
- s_valid  in  1  input sample valid
- s_ready  out  1  input ready
- s_data  in  32  float32 sample
- peak_valid  out  1  peak record valid
- peak_ready  in  1  consumer accepts the record
- peak_value  out  32  float32 maximum of the excursion
- peak_index  out  IDX_W  index of the maximum sample
- rr_interval  out  IDX_W  peak_index minus the previous peak_index, modulo 2^IDX_W
- rr_valid  out  1  rr_interval meaningful (0 for the first peak after reset/enable)

Behaviour:
- Reset: state=IDLE, s_ready=0, and all outputs, index, candidate, history and refractory counter are 0.
- Accept = s_valid && s_ready.
- s_ready = enable && !(peak_valid && !peak_ready).
- Index counter increments on every accept, including refractory samples, and wraps from 2^IDX_W-1 to 0. The first accepted sample has index 0.
- Two comparator instances, both combinational in the accept cycle:
  - C1: s_data vs threshold.
  - C2: s_data vs cand_val.
  - "Above" means C1.gt only; equal to threshold counts as not above.
- IDLE: enable=1 -> SEARCH on the next cycle.
- SEARCH: on accept with C1.gt -> ABOVE; cand_val=s_data, cand_idx=index.
- ABOVE, on accept:
  - If C1.gt and C2.gt -> update cand_val and cand_idx. Ties keep the earliest sample.
  - If !C1.gt -> emit the record and go to REFRACT with refr_cnt=REFRACT. The falling sample is not a candidate.
- Emit:
  - peak_value, peak_index, rr_interval, rr_valid=has_prev and peak_valid are registered.
  - They appear the cycle after the falling sample is accepted.
  - Then prev_idx=cand_idx and has_prev=1.
- REFRACT: each accept decrements refr_cnt. The accept that brings it to 0 moves the FSM to SEARCH, so exactly REFRACT samples are ignored.
- Output hold:
  - peak_valid stays high and the fields stay stable until peak_ready=1.
  - peak_valid clears the cycle after acceptance unless a new emit occurs in the same cycle.
  - Input stalls while a record is pending, so records are never overwritten or dropped.
- enable low:
  - s_ready=0 immediately (combinational).
  - Next cycle: FSM=IDLE; candidate, refr_cnt, has_prev and index clear.
  - A pending record is retained until taken.
- threshold changes take effect on the next accepted sample; no latching.
- Negative values, ±0 and denormals are ordered per the comparator. NaN input is out of contract.

Decomposition:
- Shared package ecg_pkg:
  - FLOAT_W=32.
  - State encoding enum {IDLE, SEARCH, ABOVE, REFRACT}.
  - Float constants used by benches: F_0P5=32'h3f000000, F_1P0=32'h3f800000.
- Sub-module: the existing comparator (ports a, b, gt, lt, eq), instantiated twice. No other sub-modules.

Test Plan:
- Basic peak: threshold 3f000000; samples 3e800000, 3f400000, 3f800000, 3f600000, 3e800000, peak_ready=1 -> one peak: peak_value=3f800000, peak_index=2, rr_valid=0, peak_valid high for exactly 1 cycle, the cycle after sample 4 is accepted.
- Negative domain and ties: threshold bf000000; samples bf800000, be800000, be800000, bf800000 -> peak_value=be800000, peak_index=1. No peak for samples equal to threshold (bf000000 stream -> none).
- Refractory and R-R: REFRACT=4, threshold 3f000000:
  - Pattern: peak at idx 2 ends at idx 4; crossing at idx 6 -> ignored.
  - Second crossing at idx 12, max at idx 13, falls at idx 14 -> peak_index=13, rr_interval=11, rr_valid=1.
- Backpressure: hold peak_ready=0 for 3 cycles after peak_valid with s_valid=1 -> s_ready=0, fields stable and no index advance for 3 cycles; a beat accepted on the 4th cycle and s_ready=1 the following cycle.
- Reset / enable mid-operation: assert rst_n=0 (or enable=0) while in ABOVE with candidate 3f800000, then resume below threshold -> no peak emitted; index restarts at 0; next first peak has rr_valid=0.
- Index wrap: IDX_W=4; peaks at idx 14 and (after wrap) idx 3 -> rr_interval=5, rr_valid=1.

Source files
------------

// File: rtl/ecg_pkg.sv
// Shared types and constants for the ECG R-peak detector and its float comparator.
package ecg_pkg;

  localparam int FLOAT_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    ABOVE,
    REFRACT
  } state_t;

  localparam logic [FLOAT_W-1:0] F_0P5 = 32'h3f000000;
  localparam logic [FLOAT_W-1:0] F_1P0 = 32'h3f800000;

  // Maps an IEEE-754 single onto an unsigned key whose integer order matches
  // the numeric order (negatives are bit-inverted, positives get the sign set).
  function automatic logic [FLOAT_W-1:0] order_key(input logic [FLOAT_W-1:0] f);
    return f[FLOAT_W-1] ? ~f : {1'b1, f[FLOAT_W-2:0]};
  endfunction

endpackage

// File: rtl/ecg_peak_detector_cmp.sv
// Combinational float32 magnitude comparator: a vs b, with +0 and -0 treated as equal.
module ecg_peak_detector_cmp
  import ecg_pkg::*;
(
  input  logic [FLOAT_W-1:0] a,
  input  logic [FLOAT_W-1:0] b,
  output logic               gt,
  output logic               lt,
  output logic               eq
);

  logic               a_zero;
  logic               b_zero;
  logic [FLOAT_W-1:0] key_a;
  logic [FLOAT_W-1:0] key_b;

  assign a_zero = (a[FLOAT_W-2:0] == '0);
  assign b_zero = (b[FLOAT_W-2:0] == '0);
  assign key_a  = order_key(a);
  assign key_b  = order_key(b);

  assign eq = (a_zero && b_zero) || (key_a == key_b);
  assign gt = !eq && (key_a > key_b);
  assign lt = !eq && (key_a < key_b);

endmodule

// File: rtl/ecg_peak_detector.sv
// Streaming R-peak detector: tracks the maximum of each supra-threshold excursion of a
// float32 ECG stream and emits one record per excursion, followed by a refractory window.
module ecg_peak_detector
  import ecg_pkg::*;
#(
  parameter int IDX_W   = 16,
  parameter int REFRACT = 72
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [FLOAT_W-1:0] threshold,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [FLOAT_W-1:0] s_data,
  output logic               peak_valid,
  input  logic               peak_ready,
  output logic [FLOAT_W-1:0] peak_value,
  output logic [IDX_W-1:0]   peak_index,
  output logic [IDX_W-1:0]   rr_interval,
  output logic               rr_valid
);

  localparam logic [IDX_W-1:0] REFR_LOAD = IDX_W'(REFRACT);

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   cand_idx;
  logic [IDX_W-1:0]   prev_idx;
  logic [IDX_W-1:0]   refr_cnt;
  logic [FLOAT_W-1:0] cand_val;
  logic               has_prev;
  logic               accept;

  logic c1_gt;
  logic c2_gt;
  logic unused_c1_lt;
  logic unused_c1_eq;
  logic unused_c2_lt;
  logic unused_c2_eq;

  ecg_peak_detector_cmp u_cmp_thr (
    .a  (s_data),
    .b  (threshold),
    .gt (c1_gt),
    .lt (unused_c1_lt),
    .eq (unused_c1_eq)
  );

  ecg_peak_detector_cmp u_cmp_cand (
    .a  (s_data),
    .b  (cand_val),
    .gt (c2_gt),
    .lt (unused_c2_lt),
    .eq (unused_c2_eq)
  );

  // Input stalls while a record is pending so an emit can never overwrite it.
  assign s_ready = enable && !(peak_valid && !peak_ready);
  assign accept  = s_valid && s_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      cand_idx    <= '0;
      cand_val    <= '0;
      prev_idx    <= '0;
      has_prev    <= 1'b0;
      refr_cnt    <= '0;
      peak_valid  <= 1'b0;
      peak_value  <= '0;
      peak_index  <= '0;
      rr_interval <= '0;
      rr_valid    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments resolve last-writer-wins, so an emit below
      // overrides this clear when a record is taken and a new one lands together.
      if (peak_valid && peak_ready) peak_valid <= 1'b0;

      if (!enable) begin
        // The pending record (peak_* outputs) is deliberately left untouched.
        state    <= IDLE;
        idx      <= '0;
        cand_idx <= '0;
        cand_val <= '0;
        prev_idx <= '0;
        has_prev <= 1'b0;
        refr_cnt <= '0;
      end else begin
        if (accept) idx <= idx + IDX_W'(1);

        unique case (state)
          IDLE, SEARCH: begin
            if (accept && c1_gt) begin
              state    <= ABOVE;
              cand_val <= s_data;
              cand_idx <= idx;
            end else begin
              state <= SEARCH;
            end
          end

          ABOVE: begin
            if (accept) begin
              if (c1_gt) begin
                // Strictly greater only: ties keep the earliest sample.
                if (c2_gt) begin
                  cand_val <= s_data;
                  cand_idx <= idx;
                end
              end else begin
                peak_valid  <= 1'b1;
                peak_value  <= cand_val;
                peak_index  <= cand_idx;
                rr_interval <= cand_idx - prev_idx;
                rr_valid    <= has_prev;
                prev_idx    <= cand_idx;
                has_prev    <= 1'b1;
                refr_cnt    <= REFR_LOAD;
                state       <= ecg_pkg::REFRACT;
              end
            end
          end

          ecg_pkg::REFRACT: begin
            if (accept) begin
              refr_cnt <= refr_cnt - IDX_W'(1);
              if (refr_cnt == IDX_W'(1)) state <= SEARCH;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ecg_peak_detector.sv
// Directed self-checking bench for ecg_peak_detector: basic peak, negative/tie ordering,
// refractory and R-R, backpressure, reset/enable abort and index wrap.
module tb_ecg_peak_detector;
  import ecg_pkg::*;

  localparam int IDX_W  = 16;
  localparam int WRAP_W = 4;

  localparam logic [31:0] F_LO      = 32'h3e800000;  // 0.25
  localparam logic [31:0] F_0P75    = 32'h3f400000;
  localparam logic [31:0] F_0P875   = 32'h3f600000;
  localparam logic [31:0] F_NEG1    = 32'hbf800000;
  localparam logic [31:0] F_NEG0P5  = 32'hbf000000;
  localparam logic [31:0] F_NEG0P25 = 32'hbe800000;
  localparam logic [31:0] F_POS0    = 32'h00000000;
  localparam logic [31:0] F_NEG0    = 32'h80000000;

  typedef struct packed {
    logic [31:0] val;
    logic [15:0] idx;
    logic [15:0] rr;
    logic        rr_valid;
  } peak_rec_t;

  logic             clk        = 1'b0;
  logic             rst_n      = 1'b0;
  logic             enable     = 1'b0;
  logic [31:0]      threshold  = F_0P5;
  logic             s_valid    = 1'b0;
  logic [31:0]      s_data     = '0;
  logic             peak_ready = 1'b1;
  logic             s_ready;
  logic             peak_valid;
  logic [31:0]      peak_value;
  logic [IDX_W-1:0] peak_index;
  logic [IDX_W-1:0] rr_interval;
  logic             rr_valid;

  logic              w_peak_ready = 1'b1;
  logic              w_s_ready;
  logic              w_peak_valid;
  logic [31:0]       w_peak_value;
  logic [WRAP_W-1:0] w_peak_index;
  logic [WRAP_W-1:0] w_rr_interval;
  logic              w_rr_valid;

  peak_rec_t main_q[$];
  peak_rec_t wrap_q[$];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ecg_peak_detector #(.IDX_W(IDX_W), .REFRACT(4)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .threshold   (threshold),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .peak_valid  (peak_valid),
    .peak_ready  (peak_ready),
    .peak_value  (peak_value),
    .peak_index  (peak_index),
    .rr_interval (rr_interval),
    .rr_valid    (rr_valid)
  );

  ecg_peak_detector #(.IDX_W(WRAP_W), .REFRACT(2)) u_wrap (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .threshold   (threshold),
    .s_valid     (s_valid),
    .s_ready     (w_s_ready),
    .s_data      (s_data),
    .peak_valid  (w_peak_valid),
    .peak_ready  (w_peak_ready),
    .peak_value  (w_peak_value),
    .peak_index  (w_peak_index),
    .rr_interval (w_rr_interval),
    .rr_valid    (w_rr_valid)
  );

  // Inputs change 2 time units after posedge, so at negedge they equal what the next edge sees.
  always @(negedge clk) begin
    if (peak_valid && peak_ready)
      main_q.push_back(peak_rec_t'{val: peak_value, idx: peak_index,
                                   rr: rr_interval, rr_valid: rr_valid});
    if (w_peak_valid && w_peak_ready)
      wrap_q.push_back(peak_rec_t'{val: w_peak_value, idx: 16'(w_peak_index),
                                   rr: 16'(w_rr_interval), rr_valid: w_rr_valid});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [31:0] d);
    int n;
    n = 0;
    s_data  = d;
    s_valid = 1'b1;
    #1;
    while (!s_ready && n < 50) begin
      tick();
      n++;
    end
    check("send_ready", 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic restart();
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    main_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] t3_vec [15];

  initial begin
    t3_vec = '{F_LO, F_0P75, F_1P0, F_0P75, F_LO,
               F_LO, F_1P0, F_LO, F_LO, F_LO, F_LO, F_LO, F_0P75, F_1P0, F_LO};

    // Reset state
    repeat (2) tick();
    check("rst_s_ready",     32'(s_ready),     32'd0);
    check("rst_peak_valid",  32'(peak_valid),  32'd0);
    check("rst_peak_value",  peak_value,       32'd0);
    check("rst_peak_index",  32'(peak_index),  32'd0);
    check("rst_rr_interval", 32'(rr_interval), 32'd0);
    check("rst_rr_valid",    32'(rr_valid),    32'd0);
    rst_n = 1'b1;
    tick();
    enable = 1'b1;
    tick();

    // Basic peak
    threshold = F_0P5;
    send(F_LO); send(F_0P75); send(F_1P0); send(F_0P875);
    check("t1_no_early_peak", 32'(peak_valid), 32'd0);
    send(F_LO);
    check("t1_valid",    32'(peak_valid), 32'd1);
    check("t1_value",    peak_value,      F_1P0);
    check("t1_index",    32'(peak_index), 32'd2);
    check("t1_rr_valid", 32'(rr_valid),   32'd0);
    tick();
    check("t1_one_cycle", 32'(peak_valid), 32'd0);

    // Negative domain, ties, and samples equal to threshold
    restart();
    threshold = F_NEG0P5;
    send(F_NEG1); send(F_NEG0P25); send(F_NEG0P25); send(F_NEG1);
    tick();
    check("t2_count",    32'(main_q.size()),    32'd1);
    check("t2_value",    main_q[0].val,         F_NEG0P25);
    check("t2_index",    32'(main_q[0].idx),    32'd1);
    check("t2_rr_valid", 32'(main_q[0].rr_valid), 32'd0);
    repeat (4) send(F_NEG1);
    repeat (3) send(F_NEG0P5);
    send(F_NEG1);
    threshold = F_NEG0;
    send(F_POS0); send(F_NEG1);
    tick();
    check("t2_equal_none", 32'(main_q.size()), 32'd1);

    // Refractory window and R-R interval
    restart();
    threshold = F_0P5;
    foreach (t3_vec[i]) send(t3_vec[i]);
    tick();
    check("t3_count",    32'(main_q.size()),      32'd2);
    check("t3_first",    32'(main_q[0].idx),      32'd2);
    check("t3_index",    32'(main_q[1].idx),      32'd13);
    check("t3_value",    main_q[1].val,           F_1P0);
    check("t3_rr",       32'(main_q[1].rr),       32'd11);
    check("t3_rr_valid", 32'(main_q[1].rr_valid), 32'd1);

    // Backpressure: idx 15..18 finish refractory, peak at 20, fall at 21
    repeat (4) send(F_LO);
    peak_ready = 1'b0;
    send(F_0P75); send(F_1P0); send(F_LO);
    check("t4_valid",    32'(peak_valid),  32'd1);
    check("t4_index",    32'(peak_index),  32'd20);
    check("t4_rr",       32'(rr_interval), 32'd7);
    check("t4_rr_valid", 32'(rr_valid),    32'd1);
    s_data  = F_LO;
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t4_stall_ready", 32'(s_ready),    32'd0);
      check("t4_hold_valid",  32'(peak_valid), 32'd1);
      check("t4_hold_index",  32'(peak_index), 32'd20);
      check("t4_hold_value",  peak_value,      F_1P0);
      tick();
    end
    peak_ready = 1'b1;
    tick();
    s_valid = 1'b0;
    check("t4_valid_clear", 32'(peak_valid), 32'd0);
    check("t4_ready_back",  32'(s_ready),    32'd1);
    repeat (3) send(F_LO);
    send(F_0P75); send(F_LO);
    tick();
    check("t4_count",    32'(main_q.size()),   32'd4);
    check("t4_taken",    32'(main_q[2].idx),   32'd20);
    check("t4_no_skip",  32'(main_q[3].idx),   32'd26);
    check("t4_rr_after", 32'(main_q[3].rr),    32'd6);

    // Reset while ABOVE with candidate 1.0
    repeat (4) send(F_LO);
    send(F_1P0);
    rst_n = 1'b0;
    #1;
    check("t5_rst_index", 32'(peak_index), 32'd0);
    check("t5_rst_valid", 32'(peak_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    main_q.delete();
    send(F_LO);
    send(F_0P75); send(F_LO);
    tick();
    check("t5_rst_count",    32'(main_q.size()),      32'd1);
    check("t5_rst_index2",   32'(main_q[0].idx),      32'd1);
    check("t5_rst_value",    main_q[0].val,           F_0P75);
    check("t5_rst_rr_valid", 32'(main_q[0].rr_valid), 32'd0);

    // Enable drop while ABOVE with candidate 1.0
    repeat (4) send(F_LO);
    send(F_1P0);
    enable = 1'b0;
    #1;
    check("t5_en_ready", 32'(s_ready), 32'd0);
    tick();
    enable = 1'b1;
    tick();
    send(F_LO);
    send(F_0P75); send(F_LO);
    tick();
    check("t5_en_count",    32'(main_q.size()),      32'd2);
    check("t5_en_index",    32'(main_q[1].idx),      32'd1);
    check("t5_en_rr_valid", 32'(main_q[1].rr_valid), 32'd0);

    // Index wrap on the 4-bit instance: peaks at 14 and 3
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    wrap_q.delete();
    repeat (14) send(F_LO);
    send(F_1P0); send(F_LO);
    repeat (3) send(F_LO);
    send(F_1P0); send(F_LO);
    tick();
    check("t6_count",     32'(wrap_q.size()),      32'd2);
    check("t6_first",     32'(wrap_q[0].idx),      32'd14);
    check("t6_first_rrv", 32'(wrap_q[0].rr_valid), 32'd0);
    check("t6_index",     32'(wrap_q[1].idx),      32'd3);
    check("t6_rr",        32'(wrap_q[1].rr),       32'd5);
    check("t6_rr_valid",  32'(wrap_q[1].rr_valid), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
